// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register target: FSM state encoding,
// R/W and ACK bit values, and a helper naming the states in which the target ACKs.
package i2c_target_regs_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_WAIT      = 4'd9
   } state_t;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;
   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;

   function automatic logic target_acks(input state_t st);
      case (st)
         ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: target_acks = 1'b1;
         default:                               target_acks = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/i2c_target_regs_if.sv
// Pin and register-port bundle of the I2C register target; slave is the target side,
// master is the environment (bus driver plus register file) side.
interface i2c_target_regs_if;
   logic       scl_i;
   logic       sda_i;
   logic       sda_oe;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       busy;

   modport slave  (input  scl_i, sda_i, reg_rdata,
                   output sda_oe, reg_wr, reg_rd, reg_addr, reg_wdata, busy);
   modport master (output scl_i, sda_i, reg_rdata,
                   input  sda_oe, reg_wr, reg_rd, reg_addr, reg_wdata, busy);
endinterface

// File: rtl/i2c_target_regs_line_sync.sv
// Synchronizes raw SCL/SDA into clk, keeps one cycle of history and flags SCL edges
// plus START/STOP conditions. Lines idle high, so every flop resets to 1.
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] scl_sync_r;
   logic [1:0] sda_sync_r;
   logic       scl_prev_r;
   logic       sda_prev_r;
   logic       scl_s;

   // two-flop synchronizers followed by the edge-detect history register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_r <= 2'b11;
         sda_sync_r <= 2'b11;
         scl_prev_r <= 1'b1;
         sda_prev_r <= 1'b1;
      end else begin
         scl_sync_r <= {scl_sync_r[0], scl_i};
         sda_sync_r <= {sda_sync_r[0], sda_i};
         scl_prev_r <= scl_sync_r[1];
         sda_prev_r <= sda_sync_r[1];
      end
   end

   assign scl_s     = scl_sync_r[1];
   assign sda_s     = sda_sync_r[1];
   assign scl_rise  = scl_s & ~scl_prev_r;
   assign scl_fall  = ~scl_s & scl_prev_r;
   assign start_det = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
   assign stop_det  = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target mapping bus writes/reads onto an 8-bit register port with an
// auto-incrementing word pointer that persists across transactions.
module i2c_target_regs
   import i2c_target_regs_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = 7'h3C,
   parameter int unsigned HOLD_CYC = 4
) (
   input logic              clk,
   input logic              rst,
   i2c_target_regs_if.slave bus
);

   localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC);

   logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
   state_t     state_r, state_s;
   logic [2:0] bit_cnt_r, bit_cnt_s;
   logic [7:0] shift_r, shift_s, ptr_r, ptr_s, rx_byte_s;
   logic       rw_r, rw_s, ninth_r, ninth_s, busy_r, busy_s, rd_pend_r;
   logic [3:0] hold_cnt_r, hold_cnt_s, hold_dec_s;
   logic       sda_oe_r, sda_oe_s, drive_s, tx_bit_s;
   logic       reg_wr_r, reg_wr_s, reg_rd_r, reg_rd_s;
   logic [7:0] reg_addr_r, reg_addr_s, reg_wdata_r, reg_wdata_s;

   i2c_line_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (bus.scl_i),
      .sda_i     (bus.sda_i),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // state and datapath registers; reset releases SDA immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'h00;
         ptr_r       <= 8'h00;
         rw_r        <= 1'b0;
         ninth_r     <= 1'b0;
         busy_r      <= 1'b0;
         rd_pend_r   <= 1'b0;
         hold_cnt_r  <= 4'd0;
         sda_oe_r    <= 1'b0;
         reg_wr_r    <= 1'b0;
         reg_rd_r    <= 1'b0;
         reg_addr_r  <= 8'h00;
         reg_wdata_r <= 8'h00;
      end else begin
         state_r     <= state_s;
         bit_cnt_r   <= bit_cnt_s;
         shift_r     <= shift_s;
         ptr_r       <= ptr_s;
         rw_r        <= rw_s;
         ninth_r     <= ninth_s;
         busy_r      <= busy_s;
         rd_pend_r   <= reg_rd_r;
         hold_cnt_r  <= hold_cnt_s;
         sda_oe_r    <= sda_oe_s;
         reg_wr_r    <= reg_wr_s;
         reg_rd_r    <= reg_rd_s;
         reg_addr_r  <= reg_addr_s;
         reg_wdata_r <= reg_wdata_s;
      end
   end

   // next-state logic; START/STOP override every state and SDA only moves when the hold count expires
   always_comb begin
      state_s     = state_r;
      bit_cnt_s   = bit_cnt_r;
      ptr_s       = ptr_r;
      rw_s        = rw_r;
      ninth_s     = ninth_r;
      busy_s      = busy_r;
      reg_wr_s    = 1'b0;
      reg_rd_s    = 1'b0;
      reg_addr_s  = reg_addr_r;
      reg_wdata_s = reg_wdata_r;
      rx_byte_s   = {shift_r[6:0], sda_s};
      tx_bit_s    = rd_pend_r ? bus.reg_rdata[7] : shift_r[7];
      shift_s     = rd_pend_r ? bus.reg_rdata : shift_r;
      if (target_acks(state_r)) begin
         drive_s = ~I2C_ACK;
      end else if (state_r == ST_RDATA) begin
         drive_s = ~tx_bit_s;
      end else begin
         drive_s = 1'b0;
      end
      sda_oe_s   = (hold_cnt_r == 4'd1) ? drive_s : sda_oe_r;
      hold_dec_s = (hold_cnt_r != 4'd0) ? (hold_cnt_r - 4'd1) : 4'd0;
      hold_cnt_s = hold_dec_s;

      if (start_det || stop_det) begin
         state_s    = start_det ? ST_ADDR : ST_IDLE;
         bit_cnt_s  = 3'd0;
         ninth_s    = 1'b0;
         busy_s     = 1'b0;
         hold_cnt_s = HOLD_LD;
      end else begin
         hold_cnt_s = scl_fall ? HOLD_LD : hold_dec_s;
         case (state_r)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise) begin
                  shift_s   = rx_byte_s;
                  bit_cnt_s = bit_cnt_r + 3'd1;
                  if (bit_cnt_r != 3'd7) begin
                     state_s = state_r;
                  end else if (state_r == ST_PTR) begin
                     ptr_s   = rx_byte_s;
                     state_s = ST_PTR_ACK;
                  end else if (state_r == ST_WDATA) begin
                     reg_wr_s    = 1'b1;
                     reg_addr_s  = ptr_r;
                     reg_wdata_s = rx_byte_s;
                     ptr_s       = ptr_r + 8'd1;
                     state_s     = ST_WDATA_ACK;
                  end else if (rx_byte_s[7:1] == DEV_ADDR) begin
                     rw_s    = rx_byte_s[0] ? I2C_RW_READ : I2C_RW_WRITE;
                     busy_s  = 1'b1;
                     state_s = ST_ADDR_ACK;
                  end else begin
                     state_s = ST_WAIT;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            ST_RDATA: begin
               if (scl_rise) begin
                  bit_cnt_s = bit_cnt_r + 3'd1;
                  state_s   = (bit_cnt_r == 3'd7) ? ST_RDATA_ACK : ST_RDATA;
               end else if (scl_fall) begin
                  shift_s = {shift_r[6:0], 1'b0};
               end else begin
                  state_s = ST_RDATA;
               end
            end
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK, ST_RDATA_ACK: begin
               // ACK slots are left on the falling edge that ends the 9th clock
               if (scl_rise) begin
                  if (state_r != ST_RDATA_ACK) begin
                     ninth_s = 1'b1;
                  end else if (sda_s == I2C_NACK) begin
                     ptr_s   = ptr_r + 8'd1;
                     state_s = ST_WAIT;
                  end else begin
                     ptr_s   = ptr_r + 8'd1;
                     ninth_s = 1'b1;
                  end
               end else if (scl_fall && ninth_r) begin
                  ninth_s   = 1'b0;
                  bit_cnt_s = 3'd0;
                  if (state_r == ST_PTR_ACK || state_r == ST_WDATA_ACK) begin
                     state_s = ST_WDATA;
                  end else if (state_r == ST_ADDR_ACK && rw_r == I2C_RW_WRITE) begin
                     state_s = ST_PTR;
                  end else begin
                     state_s    = ST_RDATA;
                     reg_rd_s   = 1'b1;
                     reg_addr_s = ptr_r;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            default: state_s = state_r;
         endcase
      end
   end

   assign bus.sda_oe    = sda_oe_r;
   assign bus.reg_wr    = reg_wr_r;
   assign bus.reg_rd    = reg_rd_r;
   assign bus.reg_addr  = reg_addr_r;
   assign bus.reg_wdata = reg_wdata_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C master, register-file model, and a
// scoreboard of expected register strobes fed by a transaction-level pointer model.
`timescale 1ns/1ps
module tb_i2c_target_regs;

   localparam int Q = 10;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;
   logic bus_sda;
   int   errors = 0;
   int   checks = 0;
   int   oe_cycles = 0;
   int   busy_cycles = 0;
   logic [7:0] ptr_m = 8'h00;
   wr_t        exp_wr_q[$];
   logic [7:0] exp_rd_q[$];
   wr_t        mon_w;
   logic [7:0] mon_a;

   always #5 clk = ~clk;

   i2c_target_regs_if bus ();

   assign bus_sda   = m_sda & ~bus.sda_oe;
   assign bus.scl_i = m_scl;
   assign bus.sda_i = bus_sda;

   i2c_target_regs #(.DEV_ADDR(7'h3C), .HOLD_CYC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) begin
      if (rst) bus.reg_rdata <= 8'h00;
      else if (bus.reg_rd) bus.reg_rdata <= bus.reg_addr ^ 8'hFF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.sda_oe) oe_cycles <= oe_cycles + 1;
         if (bus.busy) busy_cycles <= busy_cycles + 1;
         if (bus.reg_wr) begin
            if (exp_wr_q.size() == 0) begin
               check("unexpected_wr", {bus.reg_addr, bus.reg_wdata}, 32'hFFFF_FFFF);
            end else begin
               mon_w = exp_wr_q.pop_front();
               check("wr_addr", bus.reg_addr, mon_w.addr);
               check("wr_data", bus.reg_wdata, mon_w.data);
            end
         end
         if (bus.reg_rd) begin
            if (exp_rd_q.size() == 0) begin
               check("unexpected_rd", bus.reg_addr, 32'hFFFF_FFFF);
            end else begin
               mon_a = exp_rd_q.pop_front();
               check("rd_addr", bus.reg_addr, mon_a);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clock_bit(input logic b, output logic s);
      m_sda = b;
      tick(Q);
      m_scl = 1'b1;
      tick(Q / 2);
      s = bus_sda;
      tick(Q / 2);
      m_scl = 1'b0;
      tick(2);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b0; tick(2);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(mack, s);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] p, input logic [23:0] d,
                           input int n, input bit with_stop);
      logic ack;
      bit   match;
      match = (a == 7'h3C);
      i2c_start();
      send_byte({a, 1'b0}, ack);
      check("wr_addr_ack", ack, match ? 32'd0 : 32'd1);
      check("busy_after_addr", bus.busy, match);
      send_byte(p, ack);
      check("ptr_ack", ack, match ? 32'd0 : 32'd1);
      if (match) ptr_m = p;
      for (int i = 0; i < n; i++) begin
         if (match) begin
            exp_wr_q.push_back('{addr: ptr_m, data: d[8*i +: 8]});
            ptr_m = ptr_m + 8'd1;
         end
         send_byte(d[8*i +: 8], ack);
         check("data_ack", ack, match ? 32'd0 : 32'd1);
      end
      if (with_stop) begin
         i2c_stop();
         check("busy_after_stop", bus.busy, 32'd0);
      end
   endtask

   task automatic do_read(input logic [6:0] a, input int n, input bit with_stop);
      logic       ack;
      logic [7:0] b;
      bit         match;
      match = (a == 7'h3C);
      i2c_start();
      send_byte({a, 1'b1}, ack);
      check("rd_addr_ack", ack, match ? 32'd0 : 32'd1);
      for (int i = 0; i < n; i++) begin
         if (match) exp_rd_q.push_back(ptr_m);
         recv_byte(i == n - 1, b);
         check("rd_byte", b, match ? {24'd0, ptr_m ^ 8'hFF} : 32'hFF);
         if (match) ptr_m = ptr_m + 8'd1;
      end
      check("busy_hold", bus.busy, match);
      if (with_stop) begin
         i2c_stop();
         check("busy_after_stop", bus.busy, 32'd0);
      end
   endtask

   initial begin
      int         oe0;
      int         busy0;
      logic       s;
      logic [7:0] aw;

      tick(5);
      check("rst_sda_oe", bus.sda_oe, 32'd0);
      check("rst_reg_wr", bus.reg_wr, 32'd0);
      check("rst_reg_rd", bus.reg_rd, 32'd0);
      check("rst_reg_addr", bus.reg_addr, 32'd0);
      check("rst_reg_wdata", bus.reg_wdata, 32'd0);
      check("rst_busy", bus.busy, 32'd0);
      rst = 1'b0;
      tick(5);

      // write 10:A5,5A then repeated-START read of two bytes (ACK, NACK)
      do_write(7'h3C, 8'h10, 24'h005AA5, 2, 1'b0);
      do_read(7'h3C, 2, 1'b1);

      // foreign address: never drives SDA, never busy, no strobes
      oe0   = oe_cycles;
      busy0 = busy_cycles;
      do_write(7'h3D, 8'h22, 24'h003311, 2, 1'b1);
      check("foreign_no_drive", oe_cycles - oe0, 32'd0);
      check("foreign_no_busy", busy_cycles - busy0, 32'd0);

      // pointer wrap FF -> 00
      do_write(7'h3C, 8'hFF, 24'h000201, 2, 1'b1);

      for (int it = 0; it < 8; it++) begin
         logic [6:0]  a;
         logic [7:0]  p;
         logic [23:0] d;
         int          n;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h3C;
         p = 8'($urandom);
         d = 24'($urandom);
         n = $urandom_range(1, 3);
         if ($urandom_range(0, 1) == 0) do_write(a, p, d, n, 1'b1);
         else do_read(a, n, 1'b1);
      end

      // STOP after four data bits: no write, pointer unchanged
      do_write(7'h3C, 8'h40, 24'h0, 0, 1'b0);
      for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), s);
      i2c_stop();
      tick(8);
      check("abort_sda_oe", bus.sda_oe, 32'd0);
      check("abort_busy", bus.busy, 32'd0);
      do_read(7'h3C, 1, 1'b1);

      // reset while the address ACK is driven
      i2c_start();
      aw = 8'h78;
      for (int i = 7; i >= 0; i--) clock_bit(aw[i], s);
      m_sda = 1'b1;
      tick(Q);
      check("ack_driven", bus.sda_oe, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_release_sda", bus.sda_oe, 32'd0);
      check("rst_release_busy", bus.busy, 32'd0);
      ptr_m = 8'h00;
      tick(3);
      rst = 1'b0;
      tick(5);
      i2c_stop();
      do_write(7'h3C, 8'h00, 24'($urandom), 1, 1'b1);
      do_read(7'h3C, 1, 1'b1);

      tick(20);
      check("wr_queue_empty", exp_wr_q.size(), 32'd0);
      check("rd_queue_empty", exp_rd_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) responder: the far end of the bus that our I2C master driver initiates on. It decodes START/STOP, matches a 7-bit device address, ACKs, and maps I2C writes and reads onto a simple 8-bit register port with an auto-incrementing word pointer. Used as a bus-functional OLED/EEPROM stand-in on-chip and as a loopback target for master bring-up.

## Interface
- DEV_ADDR, 7'h3C, 7-bit target address matched against the first byte after START
- HOLD_CYC, 4, clk cycles after a synchronized SCL falling edge before sda_oe may change (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- scl_i  in  1  raw SCL pin level (async)
- sda_i  in  1  raw SDA pin level (async)
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read strobe
- reg_addr  out  8  word pointer for current access
- reg_wdata  out  8  write data, valid with reg_wr
- reg_rdata  in  8  read data, valid exactly 1 clk after reg_rd
- busy  out  1  high from matched address ACK until STOP/START

## Operation
- scl_i/sda_i pass 2-flop synchronizers, then a registered copy for edge detect; all decisions use synced levels.
- START: synced SDA 1→0 while SCL high. STOP: SDA 0→1 while SCL high. Both take priority over any state; START (incl. repeated) → ADDR with bit counter cleared; STOP → IDLE.
- Bits sampled on SCL rising edge, MSB first; 3-bit counter, byte complete on 8th rise.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- ADDR: byte[7:1]==DEV_ADDR → ADDR_ACK (drive ACK for 9th clock); mismatch → WAIT (never drives SDA).
- R/W=0: after ACK → PTR; received byte loads pointer, ACK, → WDATA. Each WDATA byte: reg_wr pulse with reg_addr=pointer, reg_wdata=byte on the 8th SCL rise +1 clk; ACK; pointer+1.
- R/W=1: on the SCL falling edge ending ADDR_ACK or a master ACK, pulse reg_rd (reg_addr=pointer); capture reg_rdata next clk into shift register; drive bits (sda_oe = ~bit) → RDATA. After 8 bits release SDA, sample master ACK on 9th rise: ACK(0) → pointer+1, next byte; NACK(1) → pointer+1, WAIT.
- Pointer is 8-bit, wraps 8'hFF→8'h00; persists across transactions (read without PTR phase continues at last pointer). Reset clears it to 0.
- WAIT: SDA released, ignores bits until START/STOP.

## Timing
- Reset: sda_oe=0, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0, state IDLE. Reset mid-transfer releases SDA immediately (async).
- Pin-to-detect latency: 3 clk (2 sync + edge register).
- sda_oe changes only HOLD_CYC clk after synced SCL falling edge; released on the falling edge ending the ACK slot / last read bit, same HOLD_CYC delay.
- reg_rd to data capture: 1 clk; first read bit driven at HOLD_CYC ≥2 so data always ready.
- Requirement on bus: SCL low and high phases each ≥ HOLD_CYC+4 clk (e.g. 100 MHz clk supports 400 kHz).
- START/STOP during ACK slot or mid-byte: abort, no reg_wr for partial byte, sda_oe released within HOLD_CYC clk ≤ next edge.
- No clock stretching.

## Structure
- Shared package: state enum, I2C_RW_READ/WRITE constants, ACK=0/NACK=1.
- One sub-module natural: i2c_line_sync (2-flop sync + edge/START/STOP detect), instanced once for both lines.

## Test plan
- Write 3C/W, ptr 8'h10, data A5,5A, STOP → ACK all 4 bytes; reg_wr at addr 10=A5, 11=5A; pointer=12.
- Repeated START read 3C/R with reg model returning addr^8'hFF, master ACK,NACK → SDA bytes ED,EC; reg_rd at 12,13; state WAIT then IDLE on STOP.
- Address 3D/W → SDA never driven, no reg_wr/reg_rd, busy stays 0.
- Write ptr FF, data 01,02 → reg_wr at FF then 00 (wrap).
- STOP injected after 4 data bits of a write byte → no reg_wr, sda_oe=0, IDLE.
- rst asserted while driving ACK → sda_oe drops same cycle; after release, 3C/W ptr 00 ACKed normally.
